// File: rtl/operand_issue_stage_pkg.sv
// rtl/operand_issue_stage_pkg.sv - shared types and constants for the operand issue stage
// Contents: operand-source enum, issue FSM states, NOP encoding, OF/EX packet struct,
// and the operand-source priority function.
package operand_issue_stage_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FWD,
    WB_BYPASS,
    RF
  } op_sel_e;

  typedef enum logic {
    ST_RUN,
    ST_BUBBLE
  } issue_state_e;

  // Field order matters: bubble packets are built by concatenation in the top.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_load;
  } issue_pkt_t;

  // Source priority: forwarded value, then same-cycle WB write, then file.
  // x0 never takes a forwarded or bypassed value.
  function automatic op_sel_e operand_sel(input logic       fwd_en,
                                          input logic [4:0] rs,
                                          input logic       wb_en,
                                          input logic [4:0] wb_addr);
    if (fwd_en && rs != 5'd0)
      return FWD;
    else if (wb_en && wb_addr == rs && rs != 5'd0)
      return WB_BYPASS;
    else
      return RF;
  endfunction

endpackage

// File: rtl/operand_issue_stage_regfile.sv
// rtl/operand_issue_stage_regfile.sv - 32x32 RV32 integer register file
// Ports: clk, resetn (async, active-low); raddr1/rdata1, raddr2/rdata2 async reads;
// wen/waddr/wdata synchronous write. x0 reads zero and ignores writes.
module rv32_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (wen && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem[raddr2];

endmodule

// File: rtl/operand_issue_stage.sv
// rtl/operand_issue_stage.sv - RV32 operand fetch / issue stage (OF -> EX)
// Ports: clk, resetn (async, active-low)
//   of_*      decoded instruction in; of_ready back-pressure to decode
//   fwd_rs*   forwarded operands from the dependency controller
//   wb_*      register-file write port from write-back
//   stall_ofex, flush  pipeline control
//   ex_*      OF/EX pipeline register to execute
module operand_issue_stage
  import operand_issue_stage_pkg::*;
#(
  parameter int          XLEN = 32,
  parameter logic [31:0] NOP  = RV_NOP
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            of_valid,
  input  logic [XLEN-1:0] of_instr,
  input  logic [XLEN-1:0] of_pc,
  input  logic [XLEN-1:0] of_imm,
  input  logic [4:0]      of_rs1,
  input  logic [4:0]      of_rs2,
  input  logic [4:0]      of_rd,
  input  logic            of_rd_wen,
  input  logic            of_is_load,
  output logic            of_ready,
  input  logic            fwd_rs1_enable,
  input  logic            fwd_rs2_enable,
  input  logic [XLEN-1:0] fwd_rs1_data,
  input  logic [XLEN-1:0] fwd_rs2_data,
  input  logic            wb_enable,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            stall_ofex,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_instr,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_wen,
  output logic            ex_is_load
);

  localparam issue_pkt_t BUBBLE_PKT = {1'b0, NOP, 135'd0};

  issue_state_e state_q, state_d;
  issue_pkt_t   pkt_q, pkt_d, cap_pkt;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [31:0]  rs1_val, rs2_val;
  op_sel_e      sel1, sel2;
  logic         hazard;

  rv32_regfile u_regfile (
    .clk    (clk),
    .resetn (resetn),
    .raddr1 (of_rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (of_rs2),
    .rdata2 (rf_rdata2),
    .wen    (wb_enable),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  always_comb begin
    sel1 = operand_sel(fwd_rs1_enable, of_rs1, wb_enable, wb_addr);
    sel2 = operand_sel(fwd_rs2_enable, of_rs2, wb_enable, wb_addr);
    case (sel1)
      FWD:       rs1_val = fwd_rs1_data;
      WB_BYPASS: rs1_val = wb_data;
      default:   rs1_val = rf_rdata1;
    endcase
    case (sel2)
      FWD:       rs2_val = fwd_rs2_data;
      WB_BYPASS: rs2_val = wb_data;
      default:   rs2_val = rf_rdata2;
    endcase
  end

  // A load in EX has no data until after MEM; its consumer must wait one slot.
  assign hazard = pkt_q.valid && pkt_q.is_load && pkt_q.rd_wen && (pkt_q.rd != 5'd0) &&
                  of_valid && (of_rs1 == pkt_q.rd || of_rs2 == pkt_q.rd);

  assign of_ready = !stall_ofex && !hazard;

  always_comb begin
    cap_pkt          = BUBBLE_PKT;
    cap_pkt.valid    = 1'b1;
    cap_pkt.instr    = of_instr;
    cap_pkt.pc       = of_pc;
    cap_pkt.imm      = of_imm;
    cap_pkt.rs1_data = rs1_val;
    cap_pkt.rs2_data = rs2_val;
    cap_pkt.rd       = of_rd;
    cap_pkt.rd_wen   = of_rd_wen;
    cap_pkt.is_load  = of_is_load;
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    if (flush) begin
      state_d = ST_RUN;
      pkt_d   = BUBBLE_PKT;
    end else if (!stall_ofex) begin
      if (state_q == ST_RUN && hazard) begin
        state_d = ST_BUBBLE;
        pkt_d   = BUBBLE_PKT;
      end else begin
        // Leaving BUBBLE: EX now holds a bubble, so the hazard term is clear.
        state_d = ST_RUN;
        pkt_d   = of_valid ? cap_pkt : BUBBLE_PKT;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      pkt_q   <= BUBBLE_PKT;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  assign ex_valid    = pkt_q.valid;
  assign ex_instr    = pkt_q.instr;
  assign ex_pc       = pkt_q.pc;
  assign ex_imm      = pkt_q.imm;
  assign ex_rs1_data = pkt_q.rs1_data;
  assign ex_rs2_data = pkt_q.rs2_data;
  assign ex_rd       = pkt_q.rd;
  assign ex_rd_wen   = pkt_q.rd_wen;
  assign ex_is_load  = pkt_q.is_load;

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb/tb_operand_issue_stage.sv - self-checking bench for operand_issue_stage
module tb_operand_issue_stage;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        of_valid, of_rd_wen, of_is_load, of_ready;
  logic [31:0] of_instr, of_pc, of_imm;
  logic [4:0]  of_rs1, of_rs2, of_rd;
  logic        fwd_rs1_enable, fwd_rs2_enable;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall_ofex, flush;
  logic        ex_valid, ex_rd_wen, ex_is_load;
  logic [31:0] ex_instr, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_issue_stage dut (
    .clk(clk), .resetn(resetn),
    .of_valid(of_valid), .of_instr(of_instr), .of_pc(of_pc), .of_imm(of_imm),
    .of_rs1(of_rs1), .of_rs2(of_rs2), .of_rd(of_rd),
    .of_rd_wen(of_rd_wen), .of_is_load(of_is_load), .of_ready(of_ready),
    .fwd_rs1_enable(fwd_rs1_enable), .fwd_rs2_enable(fwd_rs2_enable),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_ofex(stall_ofex), .flush(flush),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load)
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] instr, pc, imm, r1, r2;
    logic [4:0]  rd;
    logic        wen, ld;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [4:0] rd, input logic wen, input logic ld);
    exp_t e;
    e.tag = tag; e.valid = v; e.instr = instr; e.pc = pc; e.imm = imm;
    e.r1 = r1; e.r2 = r2; e.rd = rd; e.wen = wen; e.ld = ld;
    return e;
  endfunction

  function automatic exp_t bub(input string tag);
    return mk(tag, 1'b0, NOP_W, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endfunction

  task automatic compare_ex(input exp_t e);
    check({e.tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
    check({e.tag, ".instr"}, ex_instr, e.instr);
    check({e.tag, ".pc"}, ex_pc, e.pc);
    check({e.tag, ".imm"}, ex_imm, e.imm);
    check({e.tag, ".rs1"}, ex_rs1_data, e.r1);
    check({e.tag, ".rs2"}, ex_rs2_data, e.r2);
    check({e.tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
    check({e.tag, ".rd_wen"}, 32'(ex_rd_wen), 32'(e.wen));
    check({e.tag, ".is_load"}, 32'(ex_is_load), 32'(e.ld));
  endtask

  // One clock edge; the OF/EX register is then compared with the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      compare_ex(e);
    end
  endtask

  task automatic set_of(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic ld);
    of_valid = v; of_instr = instr; of_pc = pc; of_imm = imm;
    of_rs1 = rs1; of_rs2 = rs2; of_rd = rd; of_rd_wen = wen; of_is_load = ld;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_enable = en; wb_addr = addr; wb_data = data;
  endtask

  task automatic idle_inputs();
    set_of(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    fwd_rs1_enable = 1'b0; fwd_rs2_enable = 1'b0;
    fwd_rs1_data = 32'd0;  fwd_rs2_data = 32'd0;
    stall_ofex = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    compare_ex(bub("reset"));
    resetn = 1'b1;
    #1;
    check("reset.of_ready", 32'(of_ready), 32'd1);

    // WB writes x5, then a reader sees it from the file.
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    sb.push_back(bub("wb_x5")); tick();
    set_wb(1'b0, 5'd0, 32'd0);
    set_of(1'b1, 32'h00028333, 32'h100, 32'd0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    sb.push_back(mk("rf_read", 1'b1, 32'h00028333, 32'h100, 32'd0, 32'hDEADBEEF, 32'd0, 5'd6, 1'b1, 1'b0));
    tick();

    // Same-cycle WB write of x7 is visible to the reader.
    set_wb(1'b1, 5'd7, 32'h12345678);
    set_of(1'b1, 32'h00538433, 32'h104, 32'h4, 5'd7, 5'd5, 5'd8, 1'b1, 1'b0);
    sb.push_back(mk("wb_bypass", 1'b1, 32'h00538433, 32'h104, 32'h4, 32'h12345678, 32'hDEADBEEF, 5'd8, 1'b1, 1'b0));
    tick();

    // Forwarding beats WB bypass on rs2; rs1 takes the WB bypass.
    set_wb(1'b1, 5'd1, 32'h1);
    fwd_rs2_enable = 1'b1; fwd_rs2_data = 32'hA5A5A5A5;
    set_of(1'b1, 32'h00108133, 32'h108, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
    sb.push_back(mk("fwd_prio", 1'b1, 32'h00108133, 32'h108, 32'd0, 32'h1, 32'hA5A5A5A5, 5'd2, 1'b1, 1'b0));
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    fwd_rs2_enable = 1'b0; fwd_rs2_data = 32'd0;

    // lw x3 then dependent add: exactly one bubble.
    set_of(1'b1, 32'h0000A183, 32'h10C, 32'd0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
    sb.push_back(mk("lw_x3", 1'b1, 32'h0000A183, 32'h10C, 32'd0, 32'h1, 32'd0, 5'd3, 1'b1, 1'b1));
    tick();
    set_of(1'b1, 32'h00118233, 32'h110, 32'd0, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0);
    set_wb(1'b1, 5'd3, 32'h55);
    #1 check("lu.of_ready_hazard", 32'(of_ready), 32'd0);
    sb.push_back(bub("lu_bubble")); tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1 check("lu.of_ready_bubble", 32'(of_ready), 32'd1);
    sb.push_back(mk("lu_add", 1'b1, 32'h00118233, 32'h110, 32'd0, 32'h55, 32'h1, 5'd4, 1'b1, 1'b0));
    tick();

    // Back-to-back dependent loads each cost one bubble.
    set_of(1'b1, 32'h0001A403, 32'h114, 32'd0, 5'd3, 5'd0, 5'd8, 1'b1, 1'b1);
    #1 check("b2b.ready0", 32'(of_ready), 32'd1);
    sb.push_back(mk("b2b_lw8", 1'b1, 32'h0001A403, 32'h114, 32'd0, 32'h55, 32'd0, 5'd8, 1'b1, 1'b1));
    tick();
    set_of(1'b1, 32'h00042483, 32'h118, 32'd0, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1);
    #1 check("b2b.ready1", 32'(of_ready), 32'd0);
    sb.push_back(bub("b2b_bub1")); tick();
    sb.push_back(mk("b2b_lw9", 1'b1, 32'h00042483, 32'h118, 32'd0, 32'd0, 32'd0, 5'd9, 1'b1, 1'b1));
    tick();
    set_of(1'b1, 32'h00048533, 32'h11C, 32'd0, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    #1 check("b2b.ready2", 32'(of_ready), 32'd0);
    sb.push_back(bub("b2b_bub2")); tick();
    sb.push_back(mk("b2b_add", 1'b1, 32'h00048533, 32'h11C, 32'd0, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0));
    tick();

    // Load to x0 never creates a hazard.
    set_of(1'b1, 32'h0000A003, 32'h120, 32'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    sb.push_back(mk("lw_x0", 1'b1, 32'h0000A003, 32'h120, 32'd0, 32'h1, 32'd0, 5'd0, 1'b1, 1'b1));
    tick();
    set_of(1'b1, 32'h00000233, 32'h124, 32'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    #1 check("x0.of_ready", 32'(of_ready), 32'd1);
    sb.push_back(mk("x0_add", 1'b1, 32'h00000233, 32'h124, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0));
    tick();

    // Stall holds EX for 3 cycles while WB still writes x11.
    stall_ofex = 1'b1;
    set_wb(1'b1, 5'd11, 32'h77);
    set_of(1'b1, 32'h00B00593, 32'h128, 32'd11, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall.of_ready", 32'(of_ready), 32'd0);
      sb.push_back(mk("stall_hold", 1'b1, 32'h00000233, 32'h124, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0));
      tick();
    end
    set_wb(1'b0, 5'd0, 32'd0);
    flush = 1'b1;
    sb.push_back(bub("flush_stall")); tick();
    flush = 1'b0; stall_ofex = 1'b0;
    set_of(1'b1, 32'h00058633, 32'h12C, 32'd0, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0);
    sb.push_back(mk("stall_wb_x11", 1'b1, 32'h00058633, 32'h12C, 32'd0, 32'h77, 32'd0, 5'd12, 1'b1, 1'b0));
    tick();

    // Reset asserted while in BUBBLE.
    set_of(1'b1, 32'h0000A603, 32'h130, 32'd0, 5'd1, 5'd0, 5'd12, 1'b1, 1'b1);
    sb.push_back(mk("rst_lw12", 1'b1, 32'h0000A603, 32'h130, 32'd0, 32'h1, 32'd0, 5'd12, 1'b1, 1'b1));
    tick();
    set_of(1'b1, 32'h000606B3, 32'h134, 32'd0, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0);
    sb.push_back(bub("rst_bubble")); tick();
    resetn = 1'b0;
    #1;
    compare_ex(bub("rst_async"));
    @(posedge clk);
    #1;
    compare_ex(bub("rst_held"));
    set_of(1'b1, 32'h00B28733, 32'h138, 32'd0, 5'd5, 5'd11, 5'd14, 1'b1, 1'b0);
    resetn = 1'b1;
    #1 check("rst.of_ready", 32'(of_ready), 32'd1);
    sb.push_back(mk("rst_rf_zero", 1'b1, 32'h00B28733, 32'h138, 32'd0, 32'd0, 32'd0, 5'd14, 1'b1, 1'b0));
    tick();

    idle_inputs();
    check("scoreboard.drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
